// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  // Default bus geometry.
  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] word_t;

  // Instruction fetches are always doubleword accesses.
  localparam logic [2:0] FETCH_SIZE = 3'b011;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
// Data normally wins; fetch wins once the data streak has reached its limit.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic       i_valid,
  input  logic       d_valid,
  input  logic [3:0] streak,
  output logic       grant_i,
  output logic       grant_d
);

  localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

  logic fetch_starved;

  // Pick the winner from the current requests and the data streak.
  always_comb begin
    fetch_starved = i_valid && (streak == MAX_STREAK);
    grant_d       = d_valid && !fetch_starved;
    grant_i       = i_valid && !grant_d;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the fetch port and the load/store port.
//
// Handshake: each requester raises X_valid with stable fields and holds them
// until X_ready pulses for one cycle. The arbiter latches the winner's fields
// on the grant, so later changes or a dropped valid do not affect the access
// in flight. On the bus side b_valid stays high with constant b_* fields until
// the memory returns b_ready=1; that cycle is the completion, routed
// combinationally to the granted requester's X_ready/X_rdata.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ready,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_valid,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [2:0]          d_size,
  input  logic [DATA_W/8-1:0] d_strobe,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                b_valid,
  output logic                b_write,
  output logic [ADDR_W-1:0]   b_addr,
  output logic [2:0]          b_size,
  output logic [DATA_W/8-1:0] b_strobe,
  output logic [DATA_W-1:0]   b_wdata,
  input  logic                b_ready,
  input  logic [DATA_W-1:0]   b_rdata,
  output logic [1:0]          dbg_state
);

  localparam int         STRB_W     = DATA_W / 8;
  localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

  arb_state_t          state_q, state_d;
  logic [3:0]          streak_q, streak_d;
  logic                b_valid_q, b_valid_d;
  logic                b_write_q, b_write_d;
  logic [ADDR_W-1:0]   b_addr_q, b_addr_d;
  logic [2:0]          b_size_q, b_size_d;
  logic [STRB_W-1:0]   b_strobe_q, b_strobe_d;
  logic [DATA_W-1:0]   b_wdata_q, b_wdata_d;
  logic                grant_i, grant_d;

  mem_arb_pick #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_pick (
    .i_valid(i_valid),
    .d_valid(d_valid),
    .streak (streak_q),
    .grant_i(grant_i),
    .grant_d(grant_d)
  );

  // Next state, streak and latched bus fields.
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    b_valid_d  = b_valid_q;
    b_write_d  = b_write_q;
    b_addr_d   = b_addr_q;
    b_size_d   = b_size_q;
    b_strobe_d = b_strobe_q;
    b_wdata_d  = b_wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d    = GRANT_D;
          b_valid_d  = 1'b1;
          b_write_d  = d_write;
          b_addr_d   = d_addr;
          b_size_d   = d_size;
          b_strobe_d = d_strobe;
          b_wdata_d  = d_wdata;
          // Count data wins only while fetch is actually waiting.
          if (!i_valid)                    streak_d = 4'd0;
          else if (streak_q != MAX_STREAK) streak_d = streak_q + 4'd1;
        end else if (grant_i) begin
          state_d    = GRANT_I;
          b_valid_d  = 1'b1;
          b_write_d  = 1'b0;
          b_addr_d   = i_addr;
          b_size_d   = FETCH_SIZE;
          b_strobe_d = '0;
          b_wdata_d  = '0;
          streak_d   = 4'd0;
        end
      end
      GRANT_I, GRANT_D: begin
        if (b_ready) begin
          state_d   = IDLE;
          b_valid_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        b_valid_d = 1'b0;
      end
    endcase
  end

  // State and bus registers; reset returns to IDLE with the bus idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      streak_q   <= 4'd0;
      b_valid_q  <= 1'b0;
      b_write_q  <= 1'b0;
      b_addr_q   <= '0;
      b_size_q   <= 3'd0;
      b_strobe_q <= '0;
      b_wdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      b_valid_q  <= b_valid_d;
      b_write_q  <= b_write_d;
      b_addr_q   <= b_addr_d;
      b_size_q   <= b_size_d;
      b_strobe_q <= b_strobe_d;
      b_wdata_q  <= b_wdata_d;
    end
  end

  // Route the memory completion to whichever requester owns the bus.
  always_comb begin
    i_ready = (state_q == GRANT_I) && b_ready;
    d_ready = (state_q == GRANT_D) && b_ready;
    i_rdata = i_ready ? b_rdata : '0;
    d_rdata = d_ready ? b_rdata : '0;
  end

  assign b_valid   = b_valid_q;
  assign b_write   = b_write_q;
  assign b_addr    = b_addr_q;
  assign b_size    = b_size_q;
  assign b_strobe  = b_strobe_q;
  assign b_wdata   = b_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the core's single memory bus between the instruction-fetch port and the load/store (data) port. Each requester presents a held request. The arbiter picks one, latches it, and drives it onto the bus until the memory accepts it. It then routes the completion back to the winner. The arbiter sits between the fetch stage, the memory stage (which issues the loads and stores flagged by the decode control signals) and the external memory interface.

## Interface
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: data width; strobe is `DATA_W/8`.
- `MAX_D_STREAK`, default 4: number of consecutive data grants allowed while fetch waits. Legal range 1–15.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_valid` in 1: fetch request pending.
- `i_addr` in ADDR_W: fetch address.
- `i_ready` out 1: fetch completion pulse.
- `i_rdata` out DATA_W: fetch data; valid only when `i_ready`=1.
- `d_valid` in 1: data request pending.
- `d_write` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_W: data address.
- `d_size` in 3: access size code.
- `d_strobe` in DATA_W/8: byte enables for a store.
- `d_wdata` in DATA_W: store data.
- `d_ready` out 1: data completion pulse.
- `d_rdata` out DATA_W: load data; valid only when `d_ready`=1.
- `b_valid` out 1: bus request.
- `b_write`, `b_addr`, `b_size`, `b_strobe`, `b_wdata` out: latched request fields.
- `b_ready` in 1: memory completes the access this cycle.
- `b_rdata` in DATA_W: read data; valid when `b_ready`=1.

## Operation
States are IDLE, GRANT_I and GRANT_D.

**IDLE**
- `b_valid`=0.
- Arbitration:
  - Grant D if `d_valid`, unless `i_valid` && `streak`==MAX_D_STREAK.
  - Otherwise grant I if `i_valid`.
  - Otherwise stay in IDLE.
- On a grant, latch the winner's fields into the `b_*` registers.
- A fetch grant latches `b_write`=0, `b_size`=3'b011 (doubleword), `b_strobe`=0 and `b_wdata`=0.

**Streak counter (4-bit)**
- Increments on a D grant when `i_valid`=1, saturating at MAX_D_STREAK.
- Clears on any I grant.
- Clears on a D grant with `i_valid`=0.

**GRANT_X**
- `b_valid`=1 and the `b_*` outputs hold constant.
- When `b_ready`=1: `X_ready`=1 combinationally and `X_rdata`=`b_rdata`; next state is IDLE.
- For a store, `d_rdata` is don't-care.
- The non-granted requester's `ready` stays 0.

**Requester protocol**
- A requester holds its valid and fields stable until its `ready`.
- The arbiter ignores deassertion or field changes after its grant; the latched transaction completes and `ready` still pulses.

## Timing
- Reset values: state=IDLE, `streak`=0, `b_valid`=0, all `b_*` registers=0, `i_ready`=`d_ready`=0.
- Grant decision: combinational in IDLE, registered at the clock edge. `b_valid` rises one cycle after the cycle in which the requester's valid is first seen in IDLE.
- Minimum latency is 2 cycles, valid to ready, when `b_ready` is already 1. Each extra `b_ready`=0 cycle adds one cycle.
- Each transaction is followed by one IDLE turnaround cycle. Peak throughput is one access per 2 cycles.
- `i_ready` and `d_ready` are never 1 in the same cycle. `X_ready` is never 1 outside GRANT_X.
- Simultaneous `i_valid` and `d_valid` in IDLE: D wins, except I wins when `streak`==MAX_D_STREAK.
- `b_ready` asserted while in IDLE is ignored.
- Reset asserted mid-transaction: state goes to IDLE and `b_valid` drops immediately (asynchronous). The memory side must be reset together with the arbiter.

## Structure
- Package `mem_arb_pkg` holds:
  - the `arb_state_t` enum (IDLE, GRANT_I, GRANT_D);
  - `addr_t` and `word_t` typedefs;
  - the constant `FETCH_SIZE`=3'b011.
- Sub-module `mem_arb_pick` contains the combinational winner selection. Inputs: `i_valid`, `d_valid`, `streak`. Outputs: `grant_i`, `grant_d`.
- The top-level module holds the state register, the streak counter, the latch registers and the response routing.

## Test plan
1. **Single fetch.** `i_valid`=1 with `i_addr`=0x8000_0000; `b_ready`=1 from cycle 1.
   - Required: `b_valid` and `b_addr`=0x8000_0000 at cycle 1, `b_write`=0.
   - Required: `i_ready`=1 at cycle 1 with `i_rdata`=`b_rdata`.
   - Required: back in IDLE at cycle 2.
2. **Collision.** `i_valid`=`d_valid`=1 in the same cycle, with `d_write`=1, `d_addr`=0x100, `d_strobe`=0xFF, `d_wdata`=0xDEAD_BEEF.
   - Required: the bus carries the store first; `d_ready` pulses, then the fetch is granted.
3. **Starvation bound** (MAX_D_STREAK=4). `i_valid` held high while `d_valid` stays continuously high.
   - Required: exactly 4 data grants, then 1 fetch grant, repeating.
4. **Wait states.** `b_ready` held low for 5 cycles during a load.
   - Required: `b_*` stable for all 5 cycles, `d_ready`=0 throughout, then `d_ready`=1 on the 6th cycle.
5. **Abandoned request.** `d_valid` drops one cycle after its grant.
   - Required: the transaction still completes and `d_ready` pulses.
6. **Reset mid-access.** `rst_n`=0 while in GRANT_I.
   - Required: `b_valid`=0 and state=IDLE without waiting for a clock edge.
   - Required: after release, a fresh request is served normally.
